// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES-128 key-schedule constants, state encoding and helpers.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int NB   = 128;
  localparam int WORD = 32;
  localparam int NR   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Round constants live in the low byte of word 0; indices outside 1..10 give 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_sbox4                                                            |
// | Four parallel SubBytes S-boxes applied to one 32-bit word.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aes_sbox4
  import aes_pkg::*;
(
  input  logic [WORD-1:0] word_i,
  output logic [WORD-1:0] word_o
);

  for (genvar j = 0; j < 4; j++) begin : g_byte
    assign word_o[8*j +: 8] = sbox_byte(word_i[8*j +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/inv_key_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_key_step                                                         |
// | Combinational inverse key-schedule step: round r key -> round r-1.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_key_step
  import aes_pkg::*;
(
  input  logic [NB-1:0] key_i,
  input  logic [3:0]    round_i,
  output logic [NB-1:0] key_o
);

  logic [WORD-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [WORD-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [WORD-1:0] w_sub;

  assign {w_n3, w_n2, w_n1, w_n0} = key_i;

  assign w_p3 = w_n3 ^ w_n2;
  assign w_p2 = w_n2 ^ w_n1;
  assign w_p1 = w_n1 ^ w_n0;

  aes_sbox4 u_sbox (
    .word_i ({w_p3[7:0], w_p3[31:8]}),
    .word_o (w_sub)
  );

  assign w_p0  = w_n0 ^ w_sub ^ {24'h0, rcon(round_i)};
  assign key_o = {w_p3, w_p2, w_p1, w_p0};

endmodule
`default_nettype wire

// File: rtl/key_expand_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_expand_step                                                      |
// | One forward KeyExpansion round; only built with INV_KEY_SCHED_FWD_EN.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifdef INV_KEY_SCHED_FWD_EN
module key_expand_step
  import aes_pkg::*;
(
  input  logic [NB-1:0] key_i,
  input  logic [3:0]    round_i,
  output logic [NB-1:0] key_o
);

  logic [WORD-1:0] w_k0, w_k1, w_k2, w_k3;
  logic [WORD-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [WORD-1:0] w_sub;

  assign {w_k3, w_k2, w_k1, w_k0} = key_i;

  aes_sbox4 u_sbox (
    .word_i ({w_k3[7:0], w_k3[31:8]}),
    .word_o (w_sub)
  );

  // round_i is the index of the key being produced
  assign w_n0  = w_k0 ^ w_sub ^ {24'h0, rcon(round_i)};
  assign w_n1  = w_k1 ^ w_n0;
  assign w_n2  = w_k2 ^ w_n1;
  assign w_n3  = w_k3 ^ w_n2;
  assign key_o = {w_n3, w_n2, w_n1, w_n0};

endmodule
`endif
`default_nettype wire

// File: rtl/inv_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_key_schedule                                                     |
// | Emits AES-128 round keys 10..0 one per handshake, walking backward.  |
// | INV_KEY_SCHED_FWD_EN: key_in is the cipher key, expanded first.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key_in,
  output logic          busy,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [127:0]  key_out,
  output logic [3:0]    round_out
);

  state_t        state_q, state_d;
  logic [NB-1:0] key_q, key_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [NB-1:0] w_inv_key;

  inv_key_step u_inv_step (
    .key_i   (key_q),
    .round_i (rnd_q),
    .key_o   (w_inv_key)
  );

`ifdef INV_KEY_SCHED_FWD_EN
  logic [NB-1:0] w_fwd_key;
  logic [3:0]    w_fwd_rnd;

  assign w_fwd_rnd = rnd_q + 4'd1;

  key_expand_step u_fwd_step (
    .key_i   (key_q),
    .round_i (w_fwd_rnd),
    .key_o   (w_fwd_key)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
`ifdef INV_KEY_SCHED_FWD_EN
          rnd_d   = 4'd0;
          state_d = EXPAND;
`else
          rnd_d   = 4'(NR);
          state_d = EMIT;
`endif
        end
      end
`ifdef INV_KEY_SCHED_FWD_EN
      EXPAND: begin
        key_d = w_fwd_key;
        rnd_d = w_fwd_rnd;
        if (w_fwd_rnd == 4'(NR)) state_d = EMIT;
      end
`endif
      EMIT: begin
        if (key_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = w_inv_key;
            rnd_d = rnd_q - 4'd1;
          end else begin
            // Drop the round-0 key so nothing lingers once the stream ends
            key_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_valid = (state_q == EMIT);
    busy      = (state_q != IDLE);
    key_out   = key_valid ? key_q : '0;
    round_out = key_valid ? rnd_q : 4'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inv_key_schedule                                                  |
// | Scoreboard bench: FIPS-197 word-level model vs. emitted round keys.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, key_ready, busy, key_valid;
  logic [127:0] key_in, key_out;
  logic [3:0]   round_out;

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_out   (key_out),
    .round_out (round_out)
  );

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Model keys are FIPS hex strings (byte 0 most significant); DUT packs byte 0 low.
  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = v[127-8*k -: 8];
    return o;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] rc_word(input int r);
    logic [7:0] c;
    case (r)
      1: c = 8'h01;  2: c = 8'h02;  3: c = 8'h04;  4: c = 8'h08;  5: c = 8'h10;
      6: c = 8'h20;  7: c = 8'h40;  8: c = 8'h80;  9: c = 8'h1b;  10: c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h0};
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] x);
    logic [31:0] r;
    r = {x[23:0], x[31:24]};
    return {sb(r[31:24]), sb(r[23:16]), sb(r[15:8]), sb(r[7:0])};
  endfunction

  // w[i-4] = w[i] ^ w[i-1] (or ^ SubWord(RotWord(w[i-1])) ^ Rcon for the first word)
  function automatic logic [127:0] prev_fips(input logic [127:0] f, input int r);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
    {w0, w1, w2, w3} = f;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_rot(p3) ^ rc_word(r);
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] next_fips(input logic [127:0] f, input int r);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    {w0, w1, w2, w3} = f;
    n0 = w0 ^ sub_rot(w3) ^ rc_word(r);
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_valid"}, {127'd0, key_valid}, 128'd0);
    chk({name, "_busy"},  {127'd0, busy},      128'd0);
    chk({name, "_key"},   key_out,             128'd0);
    chk({name, "_round"}, {124'd0, round_out}, 128'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold stability.
  logic         hold_v = 1'b0, prev_v = 1'b0;
  logic [127:0] hold_k, prev_k, got_r1, got_r0;
  logic [3:0]   hold_r, prev_r;
  beat_t        mb;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (hold_v && key_valid) begin
        chk("hold_key", key_out, hold_k);
        chk("hold_round", {124'd0, round_out}, {124'd0, hold_r});
      end
      hold_v = 1'b0;
      if (key_valid) chk("valid_implies_busy", {127'd0, busy}, 128'd1);
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat round=%0d key=%h", round_out, key_out);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_round", {124'd0, round_out}, {124'd0, mb.rnd});
          chk("beat_key", key_out, mb.key);
        end
        if (prev_v && int'(round_out) == int'(prev_r) - 1)
          chk("fwd_reproduces", bswap(next_fips(bswap(key_out), int'(prev_r))), prev_k);
        prev_v = 1'b1;
        prev_k = key_out;
        prev_r = round_out;
        if (round_out == 4'd1) got_r1 = key_out;
        if (round_out == 4'd0) got_r0 = key_out;
      end else if (key_valid) begin
        hold_v = 1'b1;
        hold_k = key_out;
        hold_r = round_out;
      end
    end
  end

  // mode: 0 nominal, 1 backpressure at round 5, 2 start while busy, 3 random ready, 4 reset at round 6
  task automatic run_stream(input logic [127:0] k10f, input int mode);
    logic [127:0] cur, k0f;
    beat_t        b;
    int           cyc, bp, lat_exp;
    bit           done;
    cur = k10f;
    k0f = k10f;
    for (int r = 10; r >= 0; r--) begin
      b.rnd = 4'(r);
      b.key = bswap(cur);
      exp_q.push_back(b);
      k0f = cur;
      if (r > 0) cur = prev_fips(cur, r);
    end
    @(posedge clk); #1;
`ifdef INV_KEY_SCHED_FWD_EN
    key_in  = bswap(k0f);
    lat_exp = 11;
`else
    key_in  = bswap(k10f);
    lat_exp = 1;
`endif
    start     = 1'b1;
    key_ready = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (!key_valid && cyc < 40);
    chk("first_beat_latency", 128'(cyc), 128'(lat_exp));
    chk("first_round", {124'd0, round_out}, 128'd10);

    bp   = 0;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      key_ready = 1'b1;
      start     = 1'b0;
      case (mode)
        1: if (key_valid && round_out == 4'd5 && bp < 3) begin
             key_ready = 1'b0;
             bp++;
           end
        2: if (key_valid && (round_out == 4'd7 || round_out == 4'd0)) begin
             start  = 1'b1;
             key_in = ~key_in;
           end
        3: key_ready = 1'($urandom_range(0, 1));
        4: if (key_valid && round_out == 4'd6) begin
             rst       = 1'b1;
             key_ready = 1'b0;
             exp_q.delete();
             @(posedge clk); #1;
             chk_idle_zero("reset_midstream");
             rst       = 1'b0;
             key_ready = 1'b1;
             return;
           end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    start     = 1'b0;
    key_ready = 1'b1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout mode=%0d pending=%0d", mode, exp_q.size());
      exp_q.delete();
    end
    chk("busy_after_last", {127'd0, busy}, 128'd0);
    chk("valid_after_last", {127'd0, key_valid}, 128'd0);
    @(posedge clk); #1;
    chk("still_idle", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    key_ready = 1'b0;
    key_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst = 1'b0;

    got_r1 = '0;
    got_r0 = '0;
    run_stream(A1_K10, 0);
    chk("fips_round1", got_r1, bswap(A1_K1));
    chk("fips_round0", got_r0, bswap(A1_K0));

    run_stream(A1_K10, 1);
    run_stream(A1_K10, 2);
    run_stream(A1_K10, 4);
    run_stream(A1_K10, 0);

    for (int n = 0; n < 100; n++)
      run_stream({$urandom(), $urandom(), $urandom(), $urandom()}, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Sequential AES-128 inverse key scheduler for the decryption datapath.
- Takes the final (round-10) round key and walks the schedule backward one round per cycle.
- Emits round keys 10, 9, …, 0 in decryption order over a valid/ready stream.
- Removes the need to store all 11 round keys; sits between key load and the inverse-cipher round logic.

Parameters:
- NB, 128, round key width in bits
- WORD, 32, key word width in bits
- NR, 10, number of rounds (index of the last round key)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle load strobe; sampled only in IDLE
- key_in  input  128  round-10 key; cipher key when INV_KEY_SCHED_FWD_EN is defined
- busy  output  1  high from the cycle after an accepted start until the last beat is accepted
- key_valid  output  1  key_out/round_out valid
- key_ready  input  1  consumer accepts the beat when key_valid && key_ready
- key_out  output  128  current round key
- round_out  output  4  round index of key_out (10 down to 0)

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high on rst.
- Packing:
  - Word i occupies bits [32i+31:32i].
  - Byte j of a word occupies bits [8j+7:8j].
  - FIPS byte k of the key is at bits [8k+7:8k].
  - Rcon is applied in the low byte of word 0.
- Inverse step, from key N of round r to key of round r-1:
  - w3 = N3^N2; w2 = N2^N1; w1 = N1^N0.
  - w0 = N0 ^ SubWord(RotWord(w3)) ^ Rcon[r].
  - RotWord(x) = {x[7:0], x[31:8]}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 in the low byte; all other indices give 0.
- Reset values: all outputs 0; state IDLE; internal key register 0; round counter 0.
- States:
  - IDLE: key_valid=0, busy=0. On start, load key_reg<=key_in and rnd<=NR, then go to EMIT.
  - EMIT: key_valid=1, busy=1, key_out=key_reg, round_out=rnd.
    - On handshake with rnd!=0: key_reg<=inv_step(key_reg,rnd) and rnd<=rnd-1.
    - On handshake with rnd==0: go to IDLE, clearing key_valid and busy next cycle.
- Latency: first beat (round 10) has key_valid high in the cycle after start. With key_ready held high, 11 back-to-back beats follow.
- Backpressure: while key_valid && !key_ready, key_out and round_out are held stable.
- start outside IDLE is ignored, including in the cycle of the final handshake.
- rst at any time, including mid-stream, returns to IDLE with outputs zeroed in the next cycle. No partial key survives.
- No combinational path from key_ready to key_valid.

Optional Feature:
- Macro: INV_KEY_SCHED_FWD_EN.
- Defined:
  - key_in is the cipher key (round 0).
  - start loads key_reg<=key_in and rnd<=0, then enters EXPAND (busy=1, key_valid=0).
  - EXPAND applies the forward step each cycle, using Rcon[rnd+1] and rnd<=rnd+1. At rnd==NR it enters EMIT.
  - First beat appears 11 cycles after start.
- Undefined: no EXPAND state; key_in must be the round-10 key.

Decomposition:
- Shared package aes_pkg:
  - NB, WORD, NR constants.
  - Rcon lookup function, indices 1..10.
  - State enum IDLE/EXPAND/EMIT.
- One combinational sub-module: inv_key_step.
  - Ports: round key and round index in, previous round key out.
  - Instantiates the existing 4-byte SubBytes S-box.
- The forward step under the macro reuses the existing KeyExpansion block; no new forward logic.

Test Plan:
- Nominal run:
  - Stimulus: rst, then start with key_in = FIPS-197 A.1 round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS byte order), key_ready=1.
  - Response: 11 consecutive beats with rounds 10..0; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; busy low one cycle after the last beat.
- Backpressure:
  - Stimulus: nominal run with key_ready=0 for 3 cycles while round_out=5.
  - Response: key_out/round_out stable for those cycles; round 4 follows only after the handshake; no beat is lost or duplicated.
- Start while busy:
  - Stimulus: pulse start with a different key_in at round 7, and again in the cycle of the round-0 handshake.
  - Response: both ignored; sequence unchanged; IDLE afterwards.
- Reset mid-stream:
  - Stimulus: assert rst at round 6.
  - Response: next cycle key_valid=0, busy=0, key_out=0, round_out=0. A new start then produces a full fresh sequence from round 10.
- Forward mode (INV_KEY_SCHED_FWD_EN):
  - Stimulus: start with cipher key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: key_valid first high 11 cycles later with round_out=10 and key_out=d014f9a8c9ee2589e13f0cc8b6630ca6; the sequence then matches the nominal run.
- Random keys:
  - Stimulus: 100 random round-10 keys.
  - Response: applying the forward step (KeyExpansion) to each emitted round r-1 key reproduces the round r key.
